wb_ctrl_pipe: RTL and testbench
===============================

// Module: wb_ctrl_pipe
// PURPOSE
//  Registered, parametrised writeback stage for the minicpu pipeline; successor to the combinational stage-5 WBsel decode.
//  Accepts one retiring instruction per cycle and decodes result source and destination register.
//  Waits on a valid/ready handshake for load data of variable latency and aligns/sign-extends byte and half loads.
//  Drives the register-file write port plus a forwarding port, and counts load-wait stall cycles.
// PARAMETERS
//  XLEN    32  datapath width; must be >= 32 (load alignment uses the low 32 bits)
//  RADDR_W 5   register-file address width
//  CNT_W   16  width of the saturating stall-cycle counter
// PORTS
//  clk         in   1        single clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  in_valid    in   1        stage-5 instruction valid
//  in_ready    out  1        stage can accept; = (state != WAIT_LD)
//  in_instr    in   32       stage-5 instruction word (op/rt/rd/function fields per mips.h)
//  in_alu      in   XLEN     ALU result
//  in_link     in   XLEN     link PC for JAL/JALR/BGEZAL/BLTZAL
//  in_addr_lo  in   2        low effective-address bits, for load alignment
//  flush       in   1        kill the held or incoming instruction
//  ld_valid    in   1        load data valid from the cache
//  ld_data     in   XLEN     raw load word
//  wb_sel      out  3        `select_wb_load / `select_wb_link / `select_wb_alu for the committed instruction
//  rf_we       out  1        register-file write enable, one-cycle pulse per commit
//  rf_waddr    out  RADDR_W  destination register
//  rf_wdata    out  XLEN     write data
//  fwd_valid   out  1        = rf_we; fwd_addr/fwd_data mirror rf_waddr/rf_wdata
//  fwd_addr    out  RADDR_W
//  fwd_data    out  XLEN
//  clr_stats   in   1        synchronous clear of stall_cycles
//  stall_cycles out CNT_W    cycles spent in WAIT_LD, saturating
// BEHAVIOUR
//  Reset: state=IDLE. rf_we, fwd_valid, rf_waddr, rf_wdata, stall_cycles all 0. wb_sel=`select_wb_alu.
//  Accept: accept = in_valid & in_ready & ~flush.
//   - Non-load accepted at cycle T: rf_we=1 at T+1 (latency 1); back-to-back accepts allowed every cycle.
//   - Load (LW/LH/LHU/LB/LBU) accepted at T: no write at T+1; state -> WAIT_LD at T+1.
//  WAIT_LD: in_ready=0; stall_cycles += 1 per cycle, saturating at 2^CNT_W-1.
//   - ld_valid sampled at cycle L: rf_we=1 with aligned data at L+1; state -> IDLE; in_ready=1 again at L+1.
//   - ld_valid is ignored outside WAIT_LD.
//  Destination register:
//   - SPECIAL: rd. JAL: 31.
//   - REGIMM BGEZAL/BLTZAL: 31, written regardless of branch outcome.
//   - Loads and ALU immediates: rt.
//   - Stores, branches, J, JR and unknown ops: no write.
//   - Any destination of 0 suppresses rf_we (wb_sel still updates).
//  wb_sel: same mapping as the legacy decode, registered alongside rf_we.
//   - load -> `select_wb_load; JAL, JALR, BGEZAL, BLTZAL -> `select_wb_link; else `select_wb_alu.
//  Load alignment (big-endian, lane selected by in_addr_lo, captured at accept):
//   - LB/LBU: byte, sign-/zero-extended to XLEN. LH/LHU: half (addr_lo[0] ignored). LW: word.
//  Flush:
//   - In WAIT_LD: -> IDLE next cycle, no write.
//   - flush with ld_valid in the same cycle: flush wins.
//   - flush with in_valid: instruction dropped.
//  Stats: clr_stats has priority over increment in the same cycle.
//  Reset mid-WAIT_LD: immediate return to IDLE with all outputs at reset values; a late ld_valid is ignored.
// STRUCTURE
//  - Opcode/function/rt encodings, field macros and `select_wb_* codes stay in mips.h.
//  - Add `select_wb_none and the WB state encodings (IDLE, WAIT_LD) to mips.h.
//  - One sub-module, wb_load_align: combinational; inputs (ld_data, addr_lo, op); output extended XLEN result.
//  - Top level holds the FSM, capture registers (dest, op, addr_lo, alu/link), output registers and the counter.
// TESTING
//  1. ADDU rd=5, in_alu=0x1234 at T -> rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_sel=alu at T+1.
//  2. LB rt=7, addr_lo=2, ld_valid 3 cycles later with ld_data=0x11228033 -> in_ready=0 for 3 cycles;
//     then rf_wdata=0xFFFFFF80, stall_cycles=3.
//  3. LHU rt=9, addr_lo=0, ld_data=0xBEEF0000 -> rf_wdata=0x0000BEEF.
//  4. JAL, in_link=0x400 -> rf_waddr=31, rf_wdata=0x400, wb_sel=link.
//     ADDU with rd=0 -> rf_we stays 0.
//  5. LW in WAIT_LD; flush and ld_valid in the same cycle -> no rf_we.
//     state IDLE and in_ready=1 next cycle.
//  6. reset_n low while in WAIT_LD -> outputs 0 immediately; ld_valid after release -> no write.
//     Also: CNT_W=2 with 5 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/wb_ctrl_pipe_pkg.sv
// Shared encodings for the writeback stage: MIPS opcode/function/REGIMM codes,
// writeback source selects, FSM states and the instruction destination decode.
package wb_ctrl_pipe_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [4:0] RT_BLTZAL  = 5'h10;
   localparam logic [4:0] RT_BGEZAL  = 5'h11;

   localparam logic [4:0] REG_RA     = 5'd31;

   typedef enum logic [2:0] {
      WB_SEL_ALU  = 3'd0,
      WB_SEL_LOAD = 3'd1,
      WB_SEL_LINK = 3'd2,
      WB_SEL_NONE = 3'd3
   } wb_sel_e;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_LD = 1'b1
   } wb_state_e;

   typedef struct packed {
      logic       is_load;
      logic       writes;
      logic [4:0] dest;
      wb_sel_e    sel;
   } wb_dec_t;

   function automatic wb_dec_t wb_decode(input logic [31:0] instr);
      wb_dec_t    d;
      logic       has_dest;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      logic [4:0] rd;
      op = instr[31:26];
      rt = instr[20:16];
      rd = instr[15:11];
      fn = instr[5:0];
      has_dest  = 1'b0;
      d.is_load = 1'b0;
      d.writes  = 1'b0;
      d.dest    = 5'd0;
      d.sel     = WB_SEL_ALU;
      case (op)
         OP_SPECIAL: begin
            has_dest = (fn != FN_JR);
            d.dest   = rd;
            d.sel    = (fn == FN_JALR) ? WB_SEL_LINK : WB_SEL_ALU;
         end
         // Linking branches write $ra whether or not the branch is taken.
         OP_REGIMM: begin
            if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
               has_dest = 1'b1;
               d.dest   = REG_RA;
               d.sel    = WB_SEL_LINK;
            end
         end
         OP_JAL: begin
            has_dest = 1'b1;
            d.dest   = REG_RA;
            d.sel    = WB_SEL_LINK;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            has_dest  = 1'b1;
            d.is_load = 1'b1;
            d.dest    = rt;
            d.sel     = WB_SEL_LOAD;
         end
         default: begin
            if (op >= OP_ADDI && op <= OP_LUI) begin
               has_dest = 1'b1;
               d.dest   = rt;
            end
         end
      endcase
      d.writes = has_dest && (d.dest != 5'd0);
      return d;
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Big-endian load lane select with sign/zero extension for byte, half and word loads.
module wb_load_align
   import wb_ctrl_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] ld_data,
   input  logic [1:0]      addr_lo,
   input  logic [5:0]      op,
   output logic [XLEN-1:0] result
);

   logic [31:0]            w;
   logic [7:0]             b;
   logic [15:0]            h;
   logic signed [7:0]      sb;
   logic signed [15:0]     sh;
   logic signed [XLEN-1:0] sx;

   always_comb begin
      w = ld_data[31:0];
      case (addr_lo)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h  = addr_lo[1] ? w[15:0] : w[31:16];
      sb = b;
      sh = h;
      sx = '0;
      case (op)
         OP_LB: begin
            sx     = sb;
            result = $unsigned(sx);
         end
         OP_LH: begin
            sx     = sh;
            result = $unsigned(sx);
         end
         OP_LBU:  result = XLEN'(b);
         OP_LHU:  result = XLEN'(h);
         OP_LW:   result = XLEN'(w);
         default: result = ld_data;
      endcase
   end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Registered writeback stage: destination/source decode, variable-latency load wait,
// register-file and forwarding write ports, saturating load-stall counter.
module wb_ctrl_pipe
   import wb_ctrl_pipe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_alu,
   input  logic [XLEN-1:0]    in_link,
   input  logic [1:0]         in_addr_lo,
   input  logic               flush,
   input  logic               ld_valid,
   input  logic [XLEN-1:0]    ld_data,
   output logic [2:0]         wb_sel,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_addr,
   output logic [XLEN-1:0]    fwd_data,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   stall_cycles
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   wb_state_e          state;
   wb_dec_t            dec;
   logic               accept;
   logic [XLEN-1:0]    ld_aligned;
   logic               unused_instr_bits;

   logic [4:0]         ld_dest_p1;
   logic               ld_wr_p1;
   logic [5:0]         ld_op_p1;
   logic [1:0]         ld_lo_p1;

   logic               rf_we_q;
   logic [RADDR_W-1:0] rf_waddr_q;
   logic [XLEN-1:0]    rf_wdata_q;
   wb_sel_e            wb_sel_q;
   logic [CNT_W-1:0]   stall_q;

   assign dec               = wb_decode(in_instr);
   assign in_ready          = (state != WAIT_LD);
   assign accept            = in_valid & in_ready & ~flush;
   assign unused_instr_bits = ^{in_instr[25:21], in_instr[10:6]};

   wb_load_align #(.XLEN(XLEN)) u_align (
      .ld_data (ld_data),
      .addr_lo (ld_lo_p1),
      .op      (ld_op_p1),
      .result  (ld_aligned)
   );

   // Stage boundary: stage-5 decode / load capture -> registered write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ld_dest_p1 <= '0;
         ld_wr_p1   <= 1'b0;
         ld_op_p1   <= '0;
         ld_lo_p1   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_sel_q   <= WB_SEL_ALU;
         stall_q    <= '0;
      end else begin
         rf_we_q <= 1'b0;
         if (clr_stats)
            stall_q <= '0;
         else if (state == WAIT_LD)
            stall_q <= sat_inc(stall_q);

         if (state == IDLE) begin
            if (accept) begin
               if (dec.is_load) begin
                  state      <= WAIT_LD;
                  ld_dest_p1 <= dec.dest;
                  ld_wr_p1   <= dec.writes;
                  ld_op_p1   <= in_instr[31:26];
                  ld_lo_p1   <= in_addr_lo;
               end else begin
                  rf_we_q    <= dec.writes;
                  rf_waddr_q <= RADDR_W'(dec.dest);
                  rf_wdata_q <= (dec.sel == WB_SEL_LINK) ? in_link : in_alu;
                  wb_sel_q   <= dec.sel;
               end
            end
         end else begin
            // A flush arriving with the load data still kills the write.
            if (flush) begin
               state <= IDLE;
            end else if (ld_valid) begin
               state      <= IDLE;
               rf_we_q    <= ld_wr_p1;
               rf_waddr_q <= RADDR_W'(ld_dest_p1);
               rf_wdata_q <= ld_aligned;
               wb_sel_q   <= WB_SEL_LOAD;
            end
         end
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_waddr     = rf_waddr_q;
   assign rf_wdata     = rf_wdata_q;
   assign wb_sel       = wb_sel_q;
   assign fwd_valid    = rf_we_q;
   assign fwd_addr     = rf_waddr_q;
   assign fwd_data     = rf_wdata_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed bench for wb_ctrl_pipe: decode, load wait/alignment, flush, stats and async reset.
module tb_wb_ctrl_pipe;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_alu;
   logic [31:0] in_link;
   logic [1:0]  in_addr_lo;
   logic        flush;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        clr_stats;

   logic        in_ready, rf_we, fwd_valid;
   logic [2:0]  wb_sel;
   logic [4:0]  rf_waddr, fwd_addr;
   logic [31:0] rf_wdata, fwd_data;
   logic [15:0] stall_cycles;

   logic        in_ready2, rf_we2, fwd_valid2;
   logic [2:0]  wb_sel2;
   logic [4:0]  rf_waddr2, fwd_addr2;
   logic [31:0] rf_wdata2, fwd_data2;
   logic [1:0]  stall_cycles2;

   int n_asserts = 0;
   int n_fail    = 0;

   wb_ctrl_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_alu(in_alu), .in_link(in_link), .in_addr_lo(in_addr_lo),
      .flush(flush), .ld_valid(ld_valid), .ld_data(ld_data), .wb_sel(wb_sel),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .clr_stats(clr_stats),
      .stall_cycles(stall_cycles)
   );

   wb_ctrl_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_instr(in_instr), .in_alu(in_alu), .in_link(in_link), .in_addr_lo(in_addr_lo),
      .flush(flush), .ld_valid(ld_valid), .ld_data(ld_data), .wb_sel(wb_sel2),
      .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2), .fwd_valid(fwd_valid2),
      .fwd_addr(fwd_addr2), .fwd_data(fwd_data2), .clr_stats(clr_stats),
      .stall_cycles(stall_cycles2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, 5'd0, 5'd0, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
      return {op, 5'd0, rt, 16'h0000};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_alu = '0; in_link = '0;
      in_addr_lo = '0; flush = 1'b0; ld_valid = 1'b0; ld_data = '0; clr_stats = 1'b0;
      tick(); tick();
      chk("rst_rf_we", rf_we, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wb_sel", wb_sel, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_ready", in_ready, 1);
      reset_n = 1'b1;
      tick();

      // 1. ADDU rd=5
      in_valid = 1'b1; in_instr = rtype(5'd5, 6'h21); in_alu = 32'h1234;
      tick();
      in_valid = 1'b0;
      chk("addu_we", rf_we, 1);
      chk("addu_waddr", rf_waddr, 5);
      chk("addu_wdata", rf_wdata, 32'h1234);
      chk("addu_sel", wb_sel, 0);
      chk("addu_fwd", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 5'd5, 32'h1234});
      tick();
      chk("addu_pulse", rf_we, 0);

      // 2. LB rt=7, addr_lo=2, data arrives on the third WAIT_LD cycle
      in_valid = 1'b1; in_instr = itype(6'h20, 5'd7); in_addr_lo = 2'd2; ld_data = 32'h11228033;
      tick();
      in_valid = 1'b0;
      chk("lb_ready0", in_ready, 0);
      chk("lb_nowrite", rf_we, 0);
      tick();
      chk("lb_ready1", in_ready, 0);
      tick();
      chk("lb_ready2", in_ready, 0);
      ld_valid = 1'b1;
      tick();
      chk("lb_we", rf_we, 1);
      chk("lb_waddr", rf_waddr, 7);
      chk("lb_wdata", rf_wdata, 32'hFFFFFF80);
      chk("lb_sel", wb_sel, 1);
      chk("lb_stall", stall_cycles, 3);
      chk("lb_ready_back", in_ready, 1);
      tick();
      chk("ldv_idle_ignored", rf_we, 0);
      ld_valid = 1'b0;

      // 3. LHU rt=9, addr_lo=0
      in_valid = 1'b1; in_instr = itype(6'h25, 5'd9); in_addr_lo = 2'd0; ld_data = 32'hBEEF0000;
      tick();
      in_valid = 1'b0; ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      chk("lhu_we", rf_we, 1);
      chk("lhu_waddr", rf_waddr, 9);
      chk("lhu_wdata", rf_wdata, 32'h0000BEEF);
      chk("lhu_stall", stall_cycles, 4);

      // LBU lane 3 and LH with addr_lo[0] set
      in_valid = 1'b1; in_instr = itype(6'h24, 5'd12); in_addr_lo = 2'd3; ld_data = 32'h112280F3;
      tick();
      in_valid = 1'b0; ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      chk("lbu_wdata", rf_wdata, 32'h000000F3);
      chk("lbu_waddr", rf_waddr, 12);
      in_valid = 1'b1; in_instr = itype(6'h21, 5'd14); in_addr_lo = 2'd3; ld_data = 32'h12348001;
      tick();
      in_valid = 1'b0; ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      chk("lh_wdata", rf_wdata, 32'hFFFF8001);

      // 4. back-to-back: JAL, ADDU rd=0, ADDI rt=3, BGEZAL, SW
      in_valid = 1'b1; in_instr = {6'h03, 26'h0}; in_link = 32'h400; in_alu = 32'hDEAD;
      tick();
      chk("jal_we", rf_we, 1);
      chk("jal_waddr", rf_waddr, 31);
      chk("jal_wdata", rf_wdata, 32'h400);
      chk("jal_sel", wb_sel, 2);
      in_instr = rtype(5'd0, 6'h21); in_alu = 32'h55;
      tick();
      chk("rd0_we", rf_we, 0);
      chk("rd0_sel", wb_sel, 0);
      in_instr = itype(6'h08, 5'd3); in_alu = 32'h77;
      tick();
      chk("addi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd3, 32'h77});
      in_instr = {6'h01, 5'd0, 5'h11, 16'h0}; in_link = 32'h500;
      tick();
      chk("bgezal", {rf_we, rf_waddr, rf_wdata, wb_sel}, {1'b1, 5'd31, 32'h500, 3'd2});
      in_instr = itype(6'h2B, 5'd4);
      tick();
      in_valid = 1'b0;
      chk("sw_we", rf_we, 0);

      // 5. flush and ld_valid together in WAIT_LD
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clr_stats", stall_cycles, 0);
      in_valid = 1'b1; in_instr = itype(6'h23, 5'd10); in_addr_lo = 2'd0; ld_data = 32'hAAAA5555;
      tick();
      in_valid = 1'b0; flush = 1'b1; ld_valid = 1'b1;
      tick();
      flush = 1'b0; ld_valid = 1'b0;
      chk("flush_ld_we", rf_we, 0);
      chk("flush_ld_ready", in_ready, 1);
      chk("flush_ld_stall", stall_cycles, 1);
      tick();
      chk("flush_ld_late", rf_we, 0);
      in_valid = 1'b1; in_instr = rtype(5'd6, 6'h21); in_alu = 32'h99; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_in_we", rf_we, 0);
      chk("flush_in_ready", in_ready, 1);

      // saturation: 5 WAIT_LD cycles, narrow counter pins at 3
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      in_valid = 1'b1; in_instr = itype(6'h23, 5'd11); in_addr_lo = 2'd0; ld_data = 32'hCAFEF00D;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      chk("sat_stall16", stall_cycles, 5);
      chk("sat_stall2", stall_cycles2, 3);
      chk("lw_wdata", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd11, 32'hCAFEF00D});

      // 6. async reset while waiting for load data
      in_valid = 1'b1; in_instr = itype(6'h23, 5'd13);
      tick();
      in_valid = 1'b0;
      tick();
      chk("pre_rst_ready", in_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("arst_ready", in_ready, 1);
      chk("arst_wdata", rf_wdata, 0);
      chk("arst_waddr", rf_waddr, 0);
      chk("arst_stall", stall_cycles, 0);
      chk("arst_sel", wb_sel, 0);
      #1;
      reset_n = 1'b1;
      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      chk("late_ldv_we", rf_we, 0);
      chk("late_ldv_wdata", rf_wdata, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
